sakebi_eth_fcs_inserter: RTL and testbench

//  TX framing stage that sits directly upstream of sakebi_crc32_wrapper and consumes its result.

---
 rtl/sakebi_eth_fcs_inserter.sv | 211 +++++++++++++++++++++
 tb/tb_sakebi_eth_fcs_inserter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sakebi_eth_fcs_inserter.sv
// rtl/sakebi_eth_fcs_inserter.sv - TX framing stage: pass-through, zero-pad, append FCS from external CRC engine
module sakebi_eth_fcs_inserter #(
    parameter int DATA_WIDTH = 8,
    parameter bit PAD_EN     = 1'b1,
    parameter int MIN_LEN    = 60,
    parameter bit FCS_INVERT = 1'b1
) (
    input  logic                  i_axis_ACLK,
    input  logic                  i_axis_ARESETn,
    input  logic                  i_axis_TVALID,
    input  logic [DATA_WIDTH-1:0] i_axis_TDATA,
    input  logic                  i_axis_TLAST,
    output logic                  o_axis_TREADY,
    output logic                  o_tx_TVALID,
    output logic [DATA_WIDTH-1:0] o_tx_TDATA,
    output logic                  o_tx_TLAST,
    input  logic                  i_tx_TREADY,
    output logic                  o_crc_ARESETn,
    output logic                  o_crc_TVALID,
    output logic [DATA_WIDTH-1:0] o_crc_TDATA,
    input  logic                  i_crc_TVALID,
    input  logic [31:0]           i_crc_TDATA
);

    typedef enum logic [2:0] {
        ST_REARM    = 3'd0,
        ST_IDLE     = 3'd1,
        ST_DATA     = 3'd2,
        ST_PAD      = 3'd3,
        ST_WAIT_CRC = 3'd4,
        ST_FCS      = 3'd5
    } state_t;

    state_t                r_state;
    logic                  r_crc_resetn;
    logic [31:0]           r_fcs;
    logic [15:0]           r_sent;
    logic [15:0]           r_ack;
    logic [2:0]            r_fcs_cnt;
    logic                  r_tx_valid;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_last;
    logic                  r_crc_valid;
    logic [DATA_WIDTH-1:0] r_crc_data;

    logic                  w_load_ok;
    logic                  w_accept;
    logic [16:0]           w_sent_inc;
    logic                  w_min_reached;
    logic                  w_pad_load;
    logic                  w_fcs_load;
    logic                  w_strobe;
    logic                  w_ack_live;
    logic                  w_ack_match;
    logic                  w_frame_done;
    logic [DATA_WIDTH-1:0] w_fcs_byte;

    // The output register may take a new byte when it is empty or being drained this cycle
    assign w_load_ok     = !r_tx_valid | i_tx_TREADY;
    assign o_axis_TREADY = (r_state == ST_DATA) & w_load_ok;
    assign w_accept      = i_axis_TVALID & o_axis_TREADY;

    // 17-bit arithmetic so MIN_LEN up to 65535 compares without wrap
    assign w_sent_inc    = {1'b0, r_sent} + 17'd1;
    assign w_min_reached = (w_sent_inc >= 17'(MIN_LEN));

    assign w_pad_load    = (r_state == ST_PAD) & w_load_ok & ({1'b0, r_sent} < 17'(MIN_LEN));
    assign w_fcs_load    = (r_state == ST_FCS) & w_load_ok & (r_fcs_cnt != 3'd4);
    assign w_strobe      = w_accept | w_pad_load;

    // Engine results only count once the engine has been re-armed for this frame
    assign w_ack_live    = (r_state != ST_REARM) & (r_state != ST_IDLE);

    // A pulse arriving now is included, so the final result is taken on the pulse itself;
    // without a pulse the counts must already agree before the held result is trusted
    assign w_ack_match   = i_crc_TVALID ? ((r_ack + 16'd1) == r_sent) : (r_ack == r_sent);

    // The TLAST byte is the only one still held once all four FCS bytes are loaded
    assign w_frame_done  = (r_state == ST_FCS) & (r_fcs_cnt == 3'd4) & r_tx_valid & i_tx_TREADY;

    // FCS goes out least significant byte first
    always_comb begin
        w_fcs_byte = r_fcs[7:0];
        case (r_fcs_cnt[1:0])
            2'd0:    w_fcs_byte = r_fcs[7:0];
            2'd1:    w_fcs_byte = r_fcs[15:8];
            2'd2:    w_fcs_byte = r_fcs[23:16];
            default: w_fcs_byte = r_fcs[31:24];
        endcase
    end

    // Frame sequencing; engine reset is low exactly while the FSM sits in REARM
    always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) begin
            r_state      <= ST_REARM;
            r_crc_resetn <= 1'b0;
            r_fcs        <= '0;
        end else begin
            case (r_state)
                ST_REARM: begin
                    r_state      <= ST_IDLE;
                    r_crc_resetn <= 1'b1;
                end
                ST_IDLE: begin
                    if (i_axis_TVALID) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_accept && i_axis_TLAST) begin
                        if (!PAD_EN || w_min_reached) begin
                            r_state <= ST_WAIT_CRC;
                        end else begin
                            r_state <= ST_PAD;
                        end
                    end
                end
                ST_PAD: begin
                    if (w_pad_load && w_min_reached) begin
                        r_state <= ST_WAIT_CRC;
                    end
                end
                ST_WAIT_CRC: begin
                    if (w_ack_match) begin
                        r_fcs   <= FCS_INVERT ? ~i_crc_TDATA : i_crc_TDATA;
                        r_state <= ST_FCS;
                    end
                end
                ST_FCS: begin
                    if (w_frame_done) begin
                        r_state      <= ST_REARM;
                        r_crc_resetn <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_REARM;
                    r_crc_resetn <= 1'b0;
                end
            endcase
        end
    end

    // Byte counters: strobes sent, results acknowledged, FCS bytes loaded
    always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) begin
            r_sent    <= '0;
            r_ack     <= '0;
            r_fcs_cnt <= '0;
        end else if (r_state == ST_REARM) begin
            r_sent    <= '0;
            r_ack     <= '0;
            r_fcs_cnt <= '0;
        end else begin
            if (w_strobe) begin
                r_sent <= r_sent + 16'd1;
            end
            if (w_ack_live && i_crc_TVALID) begin
                r_ack <= r_ack + 16'd1;
            end
            if (w_fcs_load) begin
                r_fcs_cnt <= r_fcs_cnt + 3'd1;
            end
        end
    end

    // Single output stage: payload, pad or FCS byte; holds while downstream stalls
    always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_tx_last  <= 1'b0;
        end else if (w_load_ok) begin
            if (w_accept) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= i_axis_TDATA;
                r_tx_last  <= 1'b0;
            end else if (w_pad_load) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= '0;
                r_tx_last  <= 1'b0;
            end else if (w_fcs_load) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= w_fcs_byte;
                r_tx_last  <= (r_fcs_cnt == 3'd3);
            end else begin
                r_tx_valid <= 1'b0;
            end
        end
    end

    // Mirror each payload/pad byte to the engine in the cycle it enters the output stage
    always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) begin
            r_crc_valid <= 1'b0;
            r_crc_data  <= '0;
        end else begin
            r_crc_valid <= w_strobe;
            if (w_strobe) begin
                r_crc_data <= w_accept ? i_axis_TDATA : '0;
            end
        end
    end

    assign o_tx_TVALID   = r_tx_valid;
    assign o_tx_TDATA    = r_tx_data;
    assign o_tx_TLAST    = r_tx_last;
    assign o_crc_ARESETn = r_crc_resetn;
    assign o_crc_TVALID  = r_crc_valid;
    assign o_crc_TDATA   = r_crc_data;

endmodule

// File: tb/tb_sakebi_eth_fcs_inserter.sv
// tb/tb_sakebi_eth_fcs_inserter.sv - randomized model-checked bench for sakebi_eth_fcs_inserter
module tb_sakebi_eth_fcs_inserter;

    logic clk;
    int   n_tests = 0;
    int   n_fail  = 0;

    // index 0: PAD_EN=0, engine latency 1; index 1: PAD_EN=1 MIN_LEN=60, engine latency 3
    logic        rst_n    [2];
    logic        in_v     [2];
    logic [7:0]  in_d     [2];
    logic        in_l     [2];
    logic        tready   [2];
    logic        tx_v     [2];
    logic [7:0]  tx_d     [2];
    logic        tx_l     [2];
    logic        tx_rdy   [2];
    logic        crc_rn   [2];
    logic        crc_v    [2];
    logic [7:0]  crc_d    [2];
    logic        eng_v    [2];
    logic [31:0] eng_d    [2];
    logic        rdy_rand [2];
    int          n_out    [2];
    int          n_strb   [2];

    logic [8:0]  exp_q  [2][$];
    logic [7:0]  strb_q [2][$];
    logic [7:0]  stage_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic int frame_len(input int d);
        int n;
        n = stage_q.size();
        if (d == 1 && n < 60) n = 60;
        return n;
    endfunction

    // Ethernet FCS of the staged payload plus any zero padding
    function automatic logic [31:0] model_fcs(input int d);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < frame_len(d); i++) begin
            c = crc_upd(c, (i < stage_q.size()) ? stage_q[i] : 8'h00);
        end
        return ~c;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic abort(input string name);
        n_fail++;
        $display("FAIL %s: timeout waiting on DUT", name);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "bench stopped on timeout");
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [3:0]  pv;
        logic [31:0] pd [4];
        logic [31:0] run;

        sakebi_eth_fcs_inserter #(
            .DATA_WIDTH(8),
            .PAD_EN    (g == 1),
            .MIN_LEN   (60),
            .FCS_INVERT(1'b1)
        ) u_dut (
            .i_axis_ACLK   (clk),
            .i_axis_ARESETn(rst_n[g]),
            .i_axis_TVALID (in_v[g]),
            .i_axis_TDATA  (in_d[g]),
            .i_axis_TLAST  (in_l[g]),
            .o_axis_TREADY (tready[g]),
            .o_tx_TVALID   (tx_v[g]),
            .o_tx_TDATA    (tx_d[g]),
            .o_tx_TLAST    (tx_l[g]),
            .i_tx_TREADY   (tx_rdy[g]),
            .o_crc_ARESETn (crc_rn[g]),
            .o_crc_TVALID  (crc_v[g]),
            .o_crc_TDATA   (crc_d[g]),
            .i_crc_TVALID  (eng_v[g]),
            .i_crc_TDATA   (eng_d[g])
        );

        // CRC engine: running reflected CRC-32, result pulse LAT cycles after each strobe
        always @(posedge clk or negedge crc_rn[g]) begin
            if (!crc_rn[g]) begin
                run <= 32'hFFFFFFFF;
                pv  <= '0;
                for (int i = 0; i < 4; i++) pd[i] <= 32'hFFFFFFFF;
            end else begin
                pv    <= {pv[2:0], crc_v[g]};
                pd[0] <= crc_upd(run, crc_d[g]);
                for (int i = 1; i < 4; i++) pd[i] <= pd[i-1];
                if (crc_v[g]) run <= crc_upd(run, crc_d[g]);
            end
        end
        assign eng_v[g] = pv[LAT-1];
        assign eng_d[g] = pd[LAT-1];

        initial begin
            tx_rdy[g] = 1'b1;
            forever begin
                @(posedge clk);
                #1;
                tx_rdy[g] = rdy_rand[g] ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end

        initial begin : chk
            logic       prev_stall;
            logic [7:0] prev_d;
            logic       prev_l;
            logic [8:0] e;
            int         lowc;
            prev_stall = 1'b0;
            prev_d     = '0;
            prev_l     = 1'b0;
            lowc       = 0;
            forever begin
                @(negedge clk);
                if (!rst_n[g]) begin
                    prev_stall = 1'b0;
                    lowc       = 0;
                end else begin
                    if (prev_stall) begin
                        check($sformatf("hold_stable_dut%0d", g), {tx_v[g], tx_l[g], tx_d[g]}, {1'b1, prev_l, prev_d});
                    end
                    prev_stall = tx_v[g] && !tx_rdy[g];
                    prev_d     = tx_d[g];
                    prev_l     = tx_l[g];
                    if (tx_v[g] && tx_rdy[g]) begin
                        n_out[g]++;
                        if (exp_q[g].size() == 0) begin
                            check($sformatf("extra_out_byte_dut%0d", g), {tx_l[g], tx_d[g]}, 9'h1FF ^ {tx_l[g], tx_d[g]});
                        end else begin
                            e = exp_q[g].pop_front();
                            check($sformatf("out_byte_dut%0d", g), {tx_l[g], tx_d[g]}, e);
                        end
                    end
                    if (crc_v[g]) begin
                        n_strb[g]++;
                        if (strb_q[g].size() == 0) begin
                            check($sformatf("extra_strobe_dut%0d", g), crc_d[g], ~crc_d[g]);
                        end else begin
                            check($sformatf("strobe_byte_dut%0d", g), crc_d[g], strb_q[g].pop_front());
                        end
                    end
                    if (!crc_rn[g]) begin
                        lowc++;
                    end else if (lowc != 0) begin
                        check($sformatf("crc_rearm_width_dut%0d", g), lowc, 1);
                        lowc = 0;
                    end
                end
            end
        end
    end

    // Queue the model's expectation for the staged frame, then drive it with random gaps
    task automatic send_frame(input int d, input int gap_max);
        logic [31:0] f;
        int          budget;
        f = model_fcs(d);
        for (int i = 0; i < frame_len(d); i++) begin
            logic [7:0] b;
            b = (i < stage_q.size()) ? stage_q[i] : 8'h00;
            exp_q[d].push_back({1'b0, b});
            strb_q[d].push_back(b);
        end
        for (int k = 0; k < 4; k++) exp_q[d].push_back({(k == 3), f[8*k +: 8]});
        for (int i = 0; i < stage_q.size(); i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                in_v[d] = 1'b0;
                @(posedge clk);
                #1;
            end
            in_v[d] = 1'b1;
            in_d[d] = stage_q[i];
            in_l[d] = (i == stage_q.size() - 1);
            budget  = 0;
            forever begin
                @(negedge clk);
                if (tready[d]) break;
                budget++;
                if (budget > 3000) abort($sformatf("input_accept_dut%0d", d));
            end
            @(posedge clk);
            #1;
        end
        in_v[d] = 1'b0;
        in_l[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int budget;
        budget = 0;
        while (exp_q[d].size() != 0) begin
            @(negedge clk);
            budget++;
            if (budget > 6000) abort($sformatf("frame_drain_dut%0d", d));
        end
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("strobe_leftover_dut%0d", d), strb_q[d].size(), 0);
    endtask

    task automatic stage_ascii();
        stage_q.delete();
        for (int i = 0; i < 9; i++) stage_q.push_back(8'h31 + 8'(i));
    endtask

    task automatic stage_random(input int len);
        stage_q.delete();
        for (int i = 0; i < len; i++) stage_q.push_back(8'($urandom));
    endtask

    initial begin
        #800000;
        abort("global_watchdog");
    end

    initial begin
        logic [7:0] t2 [8];
        t2 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; in_v[d] = 1'b0; in_d[d] = '0; in_l[d] = 1'b0;
            rdy_rand[d] = 1'b0; n_out[d] = 0; n_strb[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_outputs_dut%0d", d),
                  {tready[d], tx_v[d], tx_d[d], tx_l[d], crc_v[d], crc_d[d], crc_rn[d]}, 64'h0);
        end

        stage_ascii();
        check("model_pin_123456789", model_fcs(0), 32'hCBF43926);
        stage_q.delete();
        stage_q.push_back(8'h00);
        check("model_pin_zero_byte", model_fcs(0), 32'hD202EF8D);

        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // 1: check value frame, always ready
        stage_ascii();
        n_out[0] = 0;
        send_frame(0, 0);
        wait_done(0);
        check("t1_out_count", n_out[0], 13);

        // 2: eight-byte frame, strobe count
        stage_q.delete();
        for (int i = 0; i < 8; i++) stage_q.push_back(t2[i]);
        n_out[0] = 0; n_strb[0] = 0;
        send_frame(0, 1);
        wait_done(0);
        check("t2_out_count", n_out[0], 12);
        check("t2_strobe_count", n_strb[0], 8);

        // 3: single byte padded to 60
        stage_q.delete();
        stage_q.push_back(8'hAA);
        n_out[1] = 0; n_strb[1] = 0;
        send_frame(1, 0);
        wait_done(1);
        check("t3_out_count", n_out[1], 64);
        check("t3_strobe_count", n_strb[1], 60);

        // 4: check value frame with a stalling sink
        rdy_rand[0] = 1'b1;
        stage_ascii();
        n_out[0] = 0; n_strb[0] = 0;
        send_frame(0, 0);
        wait_done(0);
        check("t4_out_count", n_out[0], 13);
        check("t4_strobe_count", n_strb[0], 9);

        // 5: back-to-back frames on both configurations
        rdy_rand[1] = 1'b1;
        for (int d = 0; d < 2; d++) begin
            stage_random($urandom_range(1, 70));
            send_frame(d, 0);
            stage_random($urandom_range(1, 70));
            send_frame(d, 0);
            wait_done(d);
        end

        // 6: reset in the middle of the FCS bytes, then a clean frame
        begin
            int budget;
            stage_random(70);
            send_frame(1, 0);
            budget = 0;
            while (exp_q[1].size() > 2) begin
                @(negedge clk);
                budget++;
                if (budget > 3000) abort("t6_reach_fcs");
            end
            #2;
            rst_n[1] = 1'b0;
            #1;
            check("t6_reset_outputs",
                  {tready[1], tx_v[1], tx_d[1], tx_l[1], crc_v[1], crc_d[1], crc_rn[1]}, 64'h0);
            exp_q[1].delete();
            strb_q[1].delete();
            repeat (3) @(posedge clk);
            #1;
            rst_n[1] = 1'b1;
            stage_random(20);
            n_out[1] = 0;
            send_frame(1, 1);
            wait_done(1);
            check("t6_next_frame_count", n_out[1], 64);
        end

        // Random frames on both configurations with a stalling sink
        for (int it = 0; it < 12; it++) begin
            for (int d = 0; d < 2; d++) begin
                int len;
                len = $urandom_range(1, 80);
                stage_random(len);
                n_out[d] = 0;
                send_frame(d, 2);
                wait_done(d);
                check($sformatf("rand_len_dut%0d", d), n_out[d], frame_len(d) + 4);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
